lsu_ctrl: RTL and testbench

- Load/store unit that sits directly downstream of the execute-stage ALU in the RISC-V core.
- Takes the ALU result as the effective address, plus store data and funct3 from the decode/execute register.
- Runs a request/grant/response handshake to data memory with byte strobes.
- Returns sign/zero-extended load data to writeback and stalls the pipeline while busy.

---
 rtl/core_pkg.sv | 16 +
 rtl/lsu_ctrl_if.sv | 29 ++
 rtl/lsu_align.sv | 29 ++
 rtl/lsu_ctrl.sv | 108 ++++++++++
 tb/tb_lsu_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared LSU state encoding, funct3 codes and access-size decode helpers.
package core_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_e;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    // Unsigned codes only exist for loads; anything unlisted falls back to a word access.
    function automatic logic is_byte(input logic [2:0] f3, input logic we);
        return f3 == F3_B || (!we && f3 == F3_BU);
    endfunction
    function automatic logic is_half(input logic [2:0] f3, input logic we);
        return f3 == F3_H || (!we && f3 == F3_HU);
    endfunction
endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: execute-stage request, data-memory and writeback signals of the load/store unit.
interface lsu_ctrl_if;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy, err;
    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
               dmem_gnt, dmem_rvalid, dmem_rdata,
        output req_ready, dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
               wb_valid, wb_rd, wb_data, busy, err
    );
    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
               dmem_gnt, dmem_rvalid, dmem_rdata,
        input  req_ready, dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
               wb_valid, wb_rd, wb_data, busy, err
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: store lane strobes/replication and load byte/half extraction with sign/zero extension.
module lsu_align
    import core_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_ext
);
    logic        sz_b, sz_h;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    always_comb begin
        sz_b      = is_byte(funct3, we);
        sz_h      = is_half(funct3, we);
        wstrb     = !we ? 4'b0000 : sz_b ? 4'b0001 << addr_lo : sz_h ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_o   = sz_b ? {4{wdata[7:0]}} : sz_h ? {2{wdata[15:0]}} : wdata;
        byte_sel  = rdata[{addr_lo, 3'b000} +: 8];
        half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        rdata_ext = funct3 == F3_B  ? {{24{byte_sel[7]}}, byte_sel} :
                    funct3 == F3_BU ? {24'b0, byte_sel} :
                    funct3 == F3_H  ? {{16{half_sel[15]}}, half_sel} :
                    funct3 == F3_HU ? {16'b0, half_sel} : rdata;
    end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store FSM with dmem request/grant/response handshake and load timeout.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module lsu_ctrl
    import core_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input logic        clk,
    input logic        rst,
    lsu_ctrl_if.master bus
);
    lsu_state_e  state_q, state_d;
    logic        we_q, we_d, mis_q, mis_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d, rdata_ext;
    logic [4:0]  rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        accept, timeout, misaligned;

    assign accept  = bus.req_valid && state_q == IDLE;
    assign timeout = !bus.dmem_rvalid && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = is_half(bus.req_funct3, bus.req_we) ? bus.req_addr[0] :
                        !is_byte(bus.req_funct3, bus.req_we) && bus.req_addr[1:0] != 2'b00;
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        case (state_q)
            IDLE: if (accept) begin
                we_d    = bus.req_we;
                f3_d    = bus.req_funct3;
                addr_d  = bus.req_addr;
                wdata_d = bus.req_wdata;
                rd_d    = bus.req_rd;
                mis_d   = misaligned;
                state_d = misaligned ? RESP : REQ;
            end
            REQ: if (bus.dmem_gnt) begin
                state_d = we_q ? IDLE : WAIT;
                cnt_d   = '0;
            end
            WAIT: if (bus.dmem_rvalid) begin
                data_d  = rdata_ext;
                state_d = RESP;
            end else if (timeout) state_d = IDLE;
            else cnt_d = cnt_q + 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end

    lsu_align u_align (
        .funct3   (f3_q),
        .addr_lo  (addr_q[1:0]),
        .we       (we_q),
        .wdata    (wdata_q),
        .rdata    (bus.dmem_rdata),
        .wstrb    (bus.dmem_wstrb),
        .wdata_o  (bus.dmem_wdata),
        .rdata_ext(rdata_ext)
    );

    assign bus.req_ready = state_q == IDLE;
    assign bus.dmem_req  = state_q == REQ;
    assign bus.dmem_we   = we_q;
    assign bus.dmem_addr = {addr_q[31:2], 2'b00};
    assign bus.wb_valid  = state_q == RESP && !mis_q;
    assign bus.wb_rd     = rd_q;
    assign bus.wb_data   = data_q;
    assign bus.busy      = state_q != IDLE;
    // Trap errors ride the RESP slot; timeout errors fire in the last WAIT cycle.
    assign bus.err       = (state_q == WAIT && timeout) || (state_q == RESP && mis_q);
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and random load/store transactions checked against a byte-lane reference model.
module tb_lsu_ctrl;
    localparam int TO = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_vec = 0;
    int n_bad = 0;
    lsu_ctrl_if bus();

    lsu_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int st_size(input logic [2:0] f3);
        return f3 == 3'd0 ? 1 : f3 == 3'd1 ? 2 : 4;
    endfunction
    function automatic int ld_size(input logic [2:0] f3);
        return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    endfunction
    function automatic int offs(input int n, input logic [31:0] a);
        return n == 4 ? 0 : n == 2 ? (int'(a[1:0]) & 2) : int'(a[1:0]);
    endfunction
    function automatic logic [3:0] exp_strb(input int n, input int off);
        logic [3:0] s = '0;
        for (int i = 0; i < 4; i++) s[i] = (i >= off && i < off + n);
        return s;
    endfunction
    function automatic logic [31:0] exp_wdata(input int n, input logic [31:0] wd);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
        return w;
    endfunction
    function automatic logic [31:0] exp_load(input logic [2:0] f3, input int n, input int off, input logic [31:0] rd);
        logic [31:0] v, mask;
        if (n == 4) return rd;
        mask = (32'd1 << (8 * n)) - 32'd1;
        v = (rd >> (8 * off)) & mask;
        if ((f3 == 3'd0 || f3 == 3'd1) && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input logic [4:0] rd, input int gd, input int rvd, input logic [31:0] rdat, input bit no_rv);
        int n, off;
        logic mis, rv, got;
        n = we ? st_size(f3) : ld_size(f3);
        off = offs(n, a);
        mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`endif
        @(negedge clk);
        chk("idle_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = a; bus.req_wdata = wd; bus.req_rd = rd;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_addr = $urandom; bus.req_wdata = $urandom; bus.req_rd = 5'($urandom);
        if (mis) begin
            #1;
            chk("trap_err", bus.err, 1);
            chk("trap_no_req", bus.dmem_req, 0);
            chk("trap_no_wb", bus.wb_valid, 0);
            @(negedge clk); #1;
            chk("trap_ready", bus.req_ready, 1);
            chk("trap_err_off", bus.err, 0);
            chk("trap_no_req2", bus.dmem_req, 0);
            return;
        end
        for (int i = 0; i <= gd; i++) begin
            bus.dmem_gnt = (i == gd);
            bus.dmem_rvalid = 1'($urandom_range(0, 1));
            bus.dmem_rdata = $urandom;
            #1;
            chk("req_hi", bus.dmem_req, 1);
            chk("req_busy", bus.busy, 1);
            chk("req_addr", bus.dmem_addr, {a[31:2], 2'b00});
            chk("req_we", bus.dmem_we, we);
            chk("req_strb", bus.dmem_wstrb, we ? exp_strb(n, off) : 4'b0000);
            if (we) chk("req_wdata", bus.dmem_wdata, exp_wdata(n, wd));
            chk("req_no_wb", bus.wb_valid, 0);
            chk("req_no_err", bus.err, 0);
            @(negedge clk);
        end
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
        if (we) begin
            #1;
            chk("st_ready", bus.req_ready, 1);
            chk("st_req_off", bus.dmem_req, 0);
            chk("st_no_wb", bus.wb_valid, 0);
            return;
        end
        got = 1'b0;
        for (int w = 0; w < TO; w++) begin
            rv = !no_rv && w == rvd;
            bus.dmem_rvalid = rv;
            bus.dmem_rdata = rv ? rdat : $urandom;
            #1;
            chk("wait_busy", bus.busy, 1);
            chk("wait_req_off", bus.dmem_req, 0);
            chk("wait_no_wb", bus.wb_valid, 0);
            chk("wait_err", bus.err, (!rv && w == TO - 1));
            @(negedge clk);
            bus.dmem_rvalid = 1'b0;
            if (rv) begin
                got = 1'b1;
                break;
            end
        end
        #1;
        if (got) begin
            chk("wb_valid", bus.wb_valid, 1);
            chk("wb_rd", bus.wb_rd, rd);
            chk("wb_data", bus.wb_data, exp_load(f3, n, off, rdat));
            chk("resp_err", bus.err, 0);
            chk("resp_busy", bus.busy, 1);
            @(negedge clk); #1;
            chk("wb_pulse_end", bus.wb_valid, 0);
            chk("ld_ready", bus.req_ready, 1);
        end else begin
            chk("to_ready", bus.req_ready, 1);
            chk("to_no_wb", bus.wb_valid, 0);
            chk("to_err_off", bus.err, 0);
        end
    endtask

    initial begin
        bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0; bus.req_addr = 0;
        bus.req_wdata = 0; bus.req_rd = 0; bus.dmem_gnt = 0; bus.dmem_rvalid = 0; bus.dmem_rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_req", bus.dmem_req, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_wb", bus.wb_valid, 0);
        chk("rst_wbdata", bus.wb_data, 0);
        chk("rst_addr", bus.dmem_addr, 0);
        chk("rst_strb", bus.dmem_wstrb, 0);
        chk("rst_we", bus.dmem_we, 0);
        rst = 1'b0;
        run_op(1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd1, 0, 0, 0, 0);
        run_op(1, 3'b000, 32'h203, 32'h000000A5, 5'd2, 0, 0, 0, 0);
        run_op(0, 3'b000, 32'h102, 0, 5'd7, 0, 0, 32'h12F45678, 0);
        run_op(0, 3'b100, 32'h102, 0, 5'd9, 0, 0, 32'h12F45678, 0);
        run_op(0, 3'b001, 32'h102, 0, 5'd3, 0, 0, 32'h12F45678, 0);
        run_op(0, 3'b010, 32'h200, 0, 5'd12, 3, 2, 32'hCAFEF00D, 0);
        run_op(1, 3'b001, 32'h303, 32'h1234ABCD, 5'd4, 1, 0, 0, 0);
        run_op(0, 3'b010, 32'h300, 0, 5'd13, 0, 0, 0, 1);
        run_op(0, 3'b010, 32'h101, 0, 5'd14, 0, 0, 32'h89ABCDEF, 0);
        // Reset pulled while a load waits for its response.
        @(negedge clk);
        bus.req_valid = 1; bus.req_we = 0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h400; bus.req_rd = 5'd5;
        @(negedge clk);
        bus.req_valid = 0; bus.dmem_gnt = 1;
        @(negedge clk);
        bus.dmem_gnt = 0;
        @(negedge clk); #1;
        chk("mid_busy_before", bus.busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_busy", bus.busy, 0);
        chk("mid_ready", bus.req_ready, 1);
        chk("mid_req", bus.dmem_req, 0);
        chk("mid_err", bus.err, 0);
        chk("mid_wb", bus.wb_valid, 0);
        chk("mid_addr", bus.dmem_addr, 0);
        chk("mid_rd", bus.wb_rd, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 40; k++)
            run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                   5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
